// File: rtl/conv_coeff_loader.sv
// Shadow/active kernel banks for the 3x3 convolution; the active bank is streamed one coefficient per clock
// from the first cycle of every vs_i-high window. Define CONV_PRESET_EN to build in the preset kernel ROM.
module conv_coeff_loader #(
    parameter int CW    = 9,
    parameter int NCOEF = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [3:0]    wr_addr_i,
    input  logic [CW-1:0] wr_data_i,
    input  logic          commit_i,
    input  logic [1:0]    preset_sel_i,
    input  logic          preset_ld_i,
    output logic [CW-1:0] coeff_o,
    output logic          load_done_o,
    output logic          pending_o,
    output logic          abort_o
);
    localparam int IW     = $clog2(NCOEF + 1);
    localparam int CENTER = NCOEF / 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nx;
    logic [IW-1:0] w_idx_inc;
    logic [CW-1:0] r_coeff;
    logic [CW-1:0] w_coeff_nx;
    logic          r_done;
    logic          w_done_nx;
    logic          r_abort;
    logic          w_abort_nx;
    logic          r_pending;
    logic          r_armed;
    logic [CW-1:0] r_shadow [NCOEF];
    logic [CW-1:0] r_active [NCOEF];
    logic          w_addr_ok;
    logic          w_wr_acc;
    logic          w_apply;

    function automatic logic [CW-1:0] identity_coeff(input int k);
        return (k == CENTER) ? CW'(32'd1) : '0;
    endfunction

`ifdef CONV_PRESET_EN
    logic w_preset_acc;

    function automatic logic [CW-1:0] preset_coeff(input logic [1:0] sel, input int k);
        logic          is_center;
        logic          is_cross;
        logic [CW-1:0] v;
        is_center = (k == CENTER);
        is_cross  = (k == CENTER - 3) || (k == CENTER - 1) || (k == CENTER + 1) || (k == CENTER + 3);
        case (sel)
            2'd0:    v = is_center ? CW'(32'd1) : '0;
            2'd1:    v = CW'(32'd1);
            2'd2:    v = is_center ? CW'(32'd5) : (is_cross ? {CW{1'b1}} : '0);
            2'd3:    v = is_center ? CW'(-32'sd4) : (is_cross ? CW'(32'd1) : '0);
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_preset_acc = preset_ld_i & ~r_pending;
`else
    logic w_unused_preset;
    assign w_unused_preset = ^{preset_sel_i, preset_ld_i};
`endif

    assign w_addr_ok = ({28'd0, wr_addr_i} < 32'(NCOEF));
    assign w_wr_acc  = wr_valid_i & ~r_pending & w_addr_ok;
    // The shadow bank is frozen while a commit waits, so the apply copies exactly what was committed.
    assign w_apply   = (r_state == S_IDLE) & ~vs_i & r_pending;
    assign w_idx_inc = r_idx + IW'(1);

    // Shadow takes host writes or presets; active is refreshed from shadow only between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCOEF; k++) begin
                r_shadow[k] <= identity_coeff(k);
                r_active[k] <= identity_coeff(k);
            end
        end else begin
`ifdef CONV_PRESET_EN
            if (w_preset_acc) begin
                for (int k = 0; k < NCOEF; k++) begin
                    r_shadow[k] <= preset_coeff(preset_sel_i, k);
                end
            end else
`endif
            if (w_wr_acc) begin
                r_shadow[wr_addr_i] <= wr_data_i;
            end
            if (w_apply) begin
                for (int k = 0; k < NCOEF; k++) begin
                    r_active[k] <= r_shadow[k];
                end
            end
        end
    end

    // Commit bookkeeping, and arming so a window already open at reset release is never streamed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            if (w_apply) begin
                r_pending <= 1'b0;
            end else if (commit_i) begin
                r_pending <= 1'b1;
            end
            if (!vs_i) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_coeff <= '0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_coeff <= w_coeff_nx;
            r_done  <= w_done_nx;
            r_abort <= w_abort_nx;
        end
    end

    // Next-state logic: coefficient k is registered one cycle ahead so it is on coeff_o in vs cycle k.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_coeff_nx = r_coeff;
        w_done_nx  = 1'b0;
        w_abort_nx = r_abort;
        case (r_state)
            S_IDLE: begin
                w_idx_nx   = '0;
                w_coeff_nx = w_apply ? r_shadow[0] : r_active[0];
                if (vs_i && r_armed) begin
                    w_state_nx = S_STREAM;
                    w_idx_nx   = IW'(1);
                    w_coeff_nx = r_active[1];
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!vs_i) begin
                    w_abort_nx = 1'b1;
                    w_state_nx = S_IDLE;
                    w_idx_nx   = '0;
                    w_coeff_nx = r_active[0];
                end else if (r_idx == IW'(NCOEF - 1)) begin
                    w_abort_nx = 1'b0;
                    w_state_nx = S_HOLD;
                    w_idx_nx   = '0;
                    w_coeff_nx = '0;
                end else begin
                    w_idx_nx   = w_idx_inc;
                    w_coeff_nx = r_active[w_idx_inc];
                    w_done_nx  = (w_idx_inc == IW'(NCOEF - 1));
                end
            end
            S_HOLD: begin
                w_coeff_nx = '0;
                if (!vs_i) begin
                    w_state_nx = S_IDLE;
                    w_coeff_nx = r_active[0];
                end else begin
                    w_state_nx = S_HOLD;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
                w_coeff_nx = '0;
            end
        endcase
    end

    assign coeff_o     = r_coeff;
    assign load_done_o = r_done;
    assign pending_o   = r_pending;
    assign abort_o     = r_abort;
    assign wr_ready_o  = ~r_pending;

endmodule
